// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard, forwarding and deferred-flush controller for a 5-stage RISC-V pipeline.
// Also keeps saturating stall/flush statistics and a sticky stall watchdog.
module branch_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch_id,
    input  logic              branch_taken,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              regwrite_ex,
    input  logic              memread_ex,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              regwrite_mem,
    input  logic              memread_mem,
    input  logic              mem_ready,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              ctrl_src,
    output logic              if_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              wdog_err
);

    localparam int                RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_STALL);

    typedef enum logic {RUN, PEND} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               wdog_q, wdog_d;

    logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b, hit_ex, hit_mem;
    logic alu_haz, load_haz, mem_haz, mem_stall, stall, data_haz;

    always_comb begin
        hit_ex_a  = (rs1_id == rd_ex)  && (rd_ex  != '0) && regwrite_ex;
        hit_ex_b  = (rs2_id == rd_ex)  && (rd_ex  != '0) && regwrite_ex;
        hit_mem_a = (rs1_id == rd_mem) && (rd_mem != '0) && regwrite_mem;
        hit_mem_b = (rs2_id == rd_mem) && (rd_mem != '0) && regwrite_mem;
        hit_ex    = hit_ex_a  || hit_ex_b;
        hit_mem   = hit_mem_a || hit_mem_b;

        alu_haz   = branch_id && hit_ex && !memread_ex;
        load_haz  = branch_id && hit_ex && memread_ex;
        mem_haz   = branch_id && hit_mem && memread_mem && !mem_ready;
        mem_stall = memread_mem && !mem_ready;
        stall     = alu_haz || load_haz || mem_haz || mem_stall;
        data_haz  = alu_haz || load_haz || mem_haz;
    end

    // EX result wins over MEM; a load in MEM is only usable once the memory answers.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (hit_ex_a && !memread_ex)                        fwd_a = 2'b10;
        else if (hit_mem_a && (!memread_mem || mem_ready))  fwd_a = 2'b01;
        if (hit_ex_b && !memread_ex)                        fwd_b = 2'b10;
        else if (hit_mem_b && (!memread_mem || mem_ready))  fwd_b = 2'b01;
    end

    always_comb begin
        pc_write    = !stall;
        if_id_write = !stall;
        ctrl_src    = stall;
    end

    // A taken branch whose operands are ready but is frozen by the memory waits in PEND
    // so the flush lands on the first cycle the front end moves again.
    always_comb begin
        state_d  = state_q;
        if_flush = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_id && branch_taken) begin
                    if (!stall)         if_flush = 1'b1;
                    else if (!data_haz) state_d  = PEND;
                end
            end
            PEND: begin
                if (!stall) begin
                    if_flush = 1'b1;
                    state_d  = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        run_d       = '0;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (if_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (stall) run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
        wdog_d = wdog_q || (run_d == RUN_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            run_q       <= '0;
            wdog_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            run_q       <= run_d;
            wdog_q      <= wdog_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign wdog_err  = wdog_q;

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Next-generation ID-stage branch hazard and forwarding controller for the 5-stage RISC-V pipeline.
- Resolves branches in ID, like the current unit, and generalises it with:
  - parametrised register-address width;
  - a variable-latency data memory via a ready handshake;
  - a deferred IF/ID flush on taken branches;
  - saturating stall/flush statistics counters;
  - a sticky stall-watchdog error.
- Sits between the ID comparator, the pipeline registers and the PC register.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the statistics counters.
- MAX_STALL, 15, number of consecutive stall cycles after which wdog_err sets. Must be ≥ 2.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- branch_id  in  1  ID holds a conditional branch.
- branch_taken  in  1  ID comparator result. Only meaningful when branch_id=1.
- rs1_id, rs2_id  in  REG_AW  branch source registers.
- rd_ex  in  REG_AW  EX destination register.
- regwrite_ex, memread_ex  in  1  EX control.
- rd_mem  in  REG_AW  MEM destination register.
- regwrite_mem, memread_mem  in  1  MEM control.
- mem_ready  in  1  data memory completes the MEM-stage access this cycle.
- fwd_a, fwd_b  out  2  branch operand select: 10 = EX ALU result, 01 = MEM result, 00 = register file.
- pc_write  out  1  PC enable.
- if_id_write  out  1  IF/ID enable.
- ctrl_src  out  1  insert bubble into ID/EX.
- if_flush  out  1  zero IF/ID on next edge.
- stall_cnt  out  CNT_W  total stall cycles.
- flush_cnt  out  CNT_W  total flushes.
- wdog_err  out  1  sticky watchdog error.

Behaviour:
- Register 0 never matches. Every rd comparison is qualified with rd != 0 for its own stage.
- hit_ex_x means rs_x == rd_ex, rd_ex != 0 and regwrite_ex. hit_mem_x is defined the same way on the MEM fields.
- Forwarding (combinational):
  - fwd_x = 10 if hit_ex_x and !memread_ex.
  - else 01 if hit_mem_x and (!memread_mem or mem_ready).
  - else 00.
  - EX has priority over MEM.
- Hazard terms:
  - alu_haz = branch_id and hit_ex (either operand) and !memread_ex. Needs one stall: ALU result is not yet produced while the instruction is in EX.
  - load_haz = branch_id and hit_ex and memread_ex. The load needs a further stall once it reaches MEM.
  - mem_haz = branch_id and hit_mem and memread_mem and !mem_ready.
  - mem_stall = memread_mem and !mem_ready, regardless of branch. Freezes the whole front end.
  - stall = alu_haz or load_haz or mem_haz or mem_stall.
- Outputs while stall=1: pc_write=0, if_id_write=0, ctrl_src=1, fwd_x still driven.
- Flush FSM, states RUN and PEND, reset to RUN:
  - RUN, branch_id and branch_taken and !stall: if_flush=1 this cycle, flush_cnt++ on the edge, stay in RUN.
  - RUN, branch_id and branch_taken and stall caused only by mem_stall, i.e. operands already valid: go to PEND, if_flush=0.
  - PEND, stall=1: hold PEND.
  - PEND, stall=0: if_flush=1, flush_cnt++, return to RUN.
  - if_flush is never asserted in the same cycle as stall=1.
- Watchdog:
  - Internal run counter, $clog2(MAX_STALL+1) bits. Increments each stall cycle and clears on any non-stall cycle.
  - When it reaches MAX_STALL, wdog_err sets on that edge and stays set until reset.
  - The run counter saturates at MAX_STALL.
- Statistics:
  - stall_cnt increments on every stall cycle.
  - Both counters saturate at all-ones and never wrap.
- Reset (asynchronous, rst_n=0):
  - FSM to RUN; stall_cnt=0, flush_cnt=0, run counter 0, wdog_err=0.
  - Combinational outputs follow the inputs. Reset asserted in PEND drops the pending flush.

Test Plan:
1. ALU hazard: add x5 in EX (regwrite_ex=1, memread_ex=0), beq rs1_id=5 in ID. Required: one cycle with pc_write=0 and ctrl_src=1. Next cycle rd_mem=5 gives fwd_a=01 with no stall. stall_cnt=1.
2. Load hazard: lw x7 in EX, beq rs2_id=7. Required: cycle 1 stall. Cycle 2, with load in MEM and mem_ready=1, fwd_b=01 with no stall. stall_cnt=1.
3. Slow memory: lw x7 in MEM with mem_ready low for 3 cycles, branch on x7. Required: 3 stall cycles, then fwd_b=01 when mem_ready=1. stall_cnt=3.
4. Deferred flush: taken beq with unrelated operands during mem_stall lasting 2 cycles. Required: PEND entered, if_flush=0 for 2 cycles, if_flush=1 on the first free cycle, flush_cnt=1.
5. Watchdog: MAX_STALL=15, mem_ready held low for 15 cycles. Required: wdog_err=1 after the 15th stall edge and still 1 after mem_ready returns. Reset mid-run clears wdog_err and the counters, and returns the FSM to RUN.
6. x0 and saturation: rd_ex=0 with regwrite_ex=1 and rs1_id=0 gives fwd_a=00 and no stall. With CNT_W=4, 20 stall cycles leave stall_cnt=15.
